// File: rtl/router_pkg.sv
// Shared router types: flit layout and the output-arbiter grant states.
package router_pkg;

    localparam int unsigned FLIT_W   = 11;
    localparam int unsigned TAIL_BIT = FLIT_W - 1;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin pick; remembers which port last completed a packet.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset_n,
    input  logic req_0_i,
    input  logic req_1_i,
    input  logic upd_i,
    input  logic upd_port_i,
    output logic pick_o
);

    logic last_grant_q;

    // Reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (upd_i) begin
            last_grant_q <= upd_port_i;
        end
    end

    always_comb begin
        pick_o = 1'b0;
        if (req_0_i && req_1_i) begin
            pick_o = ~last_grant_q;
        end else if (req_1_i) begin
            pick_o = 1'b1;
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Output-side arbiter: grants one of two input controllers per packet and
// forwards its flits, registered, to the downstream FIFO.
module output_arbiter
    import router_pkg::*;
#(
    parameter int unsigned WIDTH     = FLIT_W,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_0,
    input  logic [WIDTH-1:0]     data_0,
    output logic                 ready_0,
    input  logic                 req_1,
    input  logic [WIDTH-1:0]     data_1,
    output logic                 ready_1,
    input  logic                 full,
    output logic                 wr_en,
    output logic [WIDTH-1:0]     data_out,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic                 busy
);

    arb_state_t           state_q, state_d;
    logic                 pick;
    logic                 xfer_port;
    logic                 xfer;
    logic                 tail;
    logic [WIDTH-1:0]     xfer_data;
    logic                 wr_en_q;
    logic [WIDTH-1:0]     data_out_q;
    logic [CNT_WIDTH-1:0] pkt_count_q;

    assign xfer_port = (state_q == GRANT1);
    assign xfer_data = xfer_port ? data_1 : data_0;
    assign xfer      = (ready_0 && req_0) || (ready_1 && req_1);
    assign tail      = xfer && xfer_data[WIDTH-1];

    rr_arbiter2 u_rr (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_0_i    (req_0),
        .req_1_i    (req_1),
        .upd_i      (tail),
        .upd_port_i (xfer_port),
        .pick_o     (pick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // On a tail, hand straight over to a waiting other port to avoid the IDLE bubble.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_0 || req_1) begin
                    state_d = pick ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                if (tail) begin
                    state_d = req_1 ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (tail) begin
                    state_d = req_0 ? GRANT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_0 = (state_q == GRANT0) && !full;
        ready_1 = (state_q == GRANT1) && !full;
        busy    = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q     <= 1'b0;
            data_out_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            wr_en_q <= xfer;
            if (xfer) begin
                data_out_q <= xfer_data;
            end
            if (tail) begin
                pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign data_out  = data_out_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Output-side counterpart of the per-input controller in each router node.
- Accepts requests from the two input controllers that can target this output and grants one of them with round-robin fairness.
- Holds the grant for a whole packet, up to and including the tail flit.
- Forwards the granted controller's flits to the downstream FIFO and drives the ready back to each requester.

Parameters:
- WIDTH, 11, flit width; bit WIDTH-1 is the tail flag, bits WIDTH-2:0 are header/payload.
- CNT_WIDTH, 16, width of the forwarded-packet counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- req_0  input  1  request from input controller 0.
- data_0  input  WIDTH  flit from input controller 0.
- ready_0  output  1  grant/accept to input controller 0.
- req_1  input  1  request from input controller 1.
- data_1  input  WIDTH  flit from input controller 1.
- ready_1  output  1  grant/accept to input controller 1.
- full  input  1  downstream FIFO cannot take a write next cycle; this is a programmable-full with at least 1 slot of slack.
- wr_en  output  1  registered write strobe to downstream FIFO.
- data_out  output  WIDTH  registered flit to downstream FIFO.
- pkt_count  output  CNT_WIDTH  packets forwarded (tail flits written); wraps.
- busy  output  1  high whenever a grant is held.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - last_grant = 1, so port 0 wins the first tie.
  - wr_en = 0, data_out = 0, pkt_count = 0, busy = 0.
  - ready_0 = 0 and ready_1 = 0.
- States: IDLE, GRANT0, GRANT1. busy = (state != IDLE).
- Ready (combinational): ready_k = (state == GRANTk) && !full. It is never high in IDLE or for the ungranted port.
- Transfer: a transfer on port k occurs in a cycle where ready_k && req_k.
  - Next edge: wr_en <= 1, data_out <= data_k.
  - Otherwise: wr_en <= 0 and data_out holds its value.
  - Latency is 1 cycle from an accepted flit to wr_en.
- IDLE transitions:
  - Only req_k high: go to GRANTk.
  - Both high: grant the port != last_grant.
  - Neither high: stay in IDLE.
  - IDLE costs one bubble cycle; no ready is asserted in IDLE.
- GRANTk:
  - The grant is locked until the tail flit is transferred (data_k[WIDTH-1] = 1 on a transfer cycle).
  - req_k deasserting mid-packet (source FIFO empty): remain in GRANTk, no transfer, no timeout.
  - full high: ready_k = 0; stall with no flit lost or duplicated.
- On tail transfer from port k:
  - last_grant <= k.
  - pkt_count <= pkt_count + 1, wrapping modulo 2^CNT_WIDTH.
  - If req of the other port is high in that same cycle: go directly to GRANT(other) with no IDLE bubble.
  - Else: go to IDLE.
- Single-flit packet (header with tail = 1): one transfer, then release as above.
- Simultaneous tail on port k and new req on port k with the other port idle: go to IDLE, then re-grant k next cycle.
- Flits are forwarded unmodified; hop-count and destination rewrite is done upstream.
- Reset mid-packet:
  - Immediate return to IDLE with all outputs at reset values.
  - The partial packet downstream is not repaired; upstream controllers are reset by the same reset_n.
- A req on the ungranted port is held by the requester. It is not latched here, and it is ignored until arbitration.

Decomposition:
- Shared package router_pkg:
  - FLIT_W = 11 and TAIL_BIT = 10.
  - flit_t typedef.
  - arb_state_t enum {IDLE, GRANT0, GRANT1}.
- Sub-module rr_arbiter2: two-request round-robin pick using last_grant; combinational pick plus the last_grant register.
- The rest (grant FSM, output register, counter) lives in output_arbiter.

Test Plan:
- Basic forward: req_0 = 1 with flits 0x005, 0x102, 0x403 (tail) and full = 0.
  - ready_0 rises 1 cycle after req_0.
  - wr_en is high for 3 consecutive cycles with data_out 0x005, 0x102, 0x403.
  - Then pkt_count = 1 and state returns to IDLE.
- Tie after reset: req_0 = req_1 = 1, each sending a 2-flit packet.
  - Port 0 is served first.
  - Port 1 is granted on the cycle after port 0's tail with no bubble.
  - Then pkt_count = 2 and last_grant = 1.
- Fairness: both ports continuously requesting 1-flit packets (0x401 / 0x402) for 10 packets.
  - data_out strictly alternates 0x401, 0x402, ...
  - pkt_count = 10.
- Backpressure: full asserted for 4 cycles in the middle of a 4-flit packet on port 1.
  - ready_1 = 0 and wr_en = 0 during the stall.
  - All 4 flits appear exactly once, in order.
- Source starvation: req_0 drops for 3 cycles after the header while req_1 = 1.
  - The grant stays on port 0 and ready_1 stays 0.
  - Port 1 is served only after port 0's tail.
- Reset and wrap:
  - Assert reset_n low mid-packet: all outputs go to 0 asynchronously, before the next clk edge.
  - Separately, preload pkt_count to 0xFFFF and send one packet: pkt_count wraps to 0x0000.
